// File: rtl/pwm_pkg.sv
// Shared defaults and output-mode encoding for the PWM compare bank.
package pwm_pkg;

   localparam int N_DEF  = 7;
   localparam int CH_DEF = 4;

   typedef enum logic {
      MODE_LEVEL  = 1'b0,
      MODE_TOGGLE = 1'b1
   } pwm_mode_e;

endpackage

// File: rtl/pwm_cmp_cell.sv
// One compare channel: shadow/active duty, match pulse and PWM output.
module pwm_cmp_cell
   import pwm_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         load_i,
   input  pwm_mode_e    mode_i,
   input  logic [N-1:0] cnt_i,
   input  logic         wr_i,
   input  logic [N-1:0] wr_duty_i,
   output logic         match_o,
   output logic         pwm_o
);

   logic [N-1:0] sh_q, sh_d;
   logic [N-1:0] act_q, act_d;
   logic         match_q, match_d;
   logic         pwm_q, pwm_d;
   logic         hit;

   assign hit = (cnt_i == act_q);

   always_comb begin
      sh_d    = wr_i ? wr_duty_i : sh_q;
      act_d   = act_q;
      match_d = 1'b0;
      pwm_d   = pwm_q;
      if (en_i) begin
         match_d = hit;
         unique case (mode_i)
            MODE_LEVEL:  pwm_d = (cnt_i < act_q);
            MODE_TOGGLE: pwm_d = pwm_q ^ hit;
         endcase
         // a write landing on the load edge goes straight to active
         if (load_i) act_d = sh_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_q    <= '0;
         act_q   <= '0;
         match_q <= 1'b0;
         pwm_q   <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         act_q   <= act_d;
         match_q <= match_d;
         pwm_q   <= pwm_d;
      end
   end

   assign match_o = match_q;
   assign pwm_o   = pwm_q;

endmodule

// File: rtl/pwm_cmp_bank.sv
// Shared period counter, wrap pulse, mode latch and duty-write decode.
module pwm_cmp_bank
   import pwm_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int CH = CH_DEF,
   localparam int WW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          mode,
   input  logic [N-1:0]  period,
   input  logic          wr_en,
   input  logic [WW-1:0] wr_ch,
   input  logic [N-1:0]  wr_duty,
   output logic [N-1:0]  cnt,
   output logic          wrap,
   output logic [CH-1:0] match,
   output logic [CH-1:0] pwm_out
);

   logic [N-1:0]  cnt_q, cnt_d;
   pwm_mode_e     mode_q, mode_d;
   logic          wrap_q;
   logic          at_end;
   logic          load;
   logic [CH-1:0] wr_hit;

   assign at_end = (cnt_q == period);
   assign load   = en & at_end;

   always_comb begin
      cnt_d  = cnt_q;
      mode_d = mode_q;
      if (en) begin
         // >= also recovers when period drops below the running count
         cnt_d = (cnt_q >= period) ? '0 : cnt_q + 1'b1;
         if (at_end) mode_d = pwm_mode_e'(mode);
      end
   end

   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < CH; i++) begin
         if (wr_en && (wr_ch == WW'(i))) wr_hit[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         mode_q <= MODE_LEVEL;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         wrap_q <= load;
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_cell
      pwm_cmp_cell #(
         .N(N)
      ) u_cell (
         .clk_i     (clk),
         .rst_i     (rst),
         .en_i      (en),
         .load_i    (load),
         .mode_i    (mode_q),
         .cnt_i     (cnt_q),
         .wr_i      (wr_hit[g]),
         .wr_duty_i (wr_duty),
         .match_o   (match[g]),
         .pwm_o     (pwm_out[g])
      );
   end

   assign cnt  = cnt_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_pwm_cmp_bank.sv
// Randomised and directed bench for pwm_cmp_bank against a behavioural model.
module tb_pwm_cmp_bank;

   localparam int N  = 7;
   localparam int CH = 4;
   localparam int WW = (CH > 1) ? $clog2(CH) : 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          mode;
   logic [N-1:0]  period;
   logic          wr_en;
   logic [WW-1:0] wr_ch;
   logic [N-1:0]  wr_duty;
   logic [N-1:0]  cnt;
   logic          wrap;
   logic [CH-1:0] match;
   logic [CH-1:0] pwm_out;

   int n_chk  = 0;
   int n_pass = 0;

   pwm_cmp_bank #(.N(N), .CH(CH)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .period  (period),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_duty (wr_duty),
      .cnt     (cnt),
      .wrap    (wrap),
      .match   (match),
      .pwm_out (pwm_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
   endtask

   // behavioural model: counter position, duty pairs, latched mode
   int m_cnt = 0;
   int m_wrap = 0;
   int m_mode = 0;
   int sh[CH];
   int act[CH];
   int m_match[CH];
   int m_pwm[CH];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0; m_wrap = 0; m_mode = 0;
         for (int i = 0; i < CH; i++) begin
            sh[i] = 0; act[i] = 0; m_match[i] = 0; m_pwm[i] = 0;
         end
      end else begin
         int p;
         bit last;
         p = int'(period);
         if (wr_en && int'(wr_ch) < CH) sh[wr_ch] = int'(wr_duty);
         if (en) begin
            last = (m_cnt == p);
            m_wrap = last;
            for (int i = 0; i < CH; i++) begin
               m_match[i] = (m_cnt == act[i]);
               if (m_mode == 0) m_pwm[i] = (m_cnt < act[i]);
               else if (m_cnt == act[i]) m_pwm[i] = 1 - m_pwm[i];
            end
            if (last) begin
               for (int i = 0; i < CH; i++) act[i] = sh[i];
               m_mode = int'(mode);
            end
            m_cnt = (m_cnt >= p) ? 0 : m_cnt + 1;
         end else begin
            m_wrap = 0;
            for (int i = 0; i < CH; i++) m_match[i] = 0;
         end
      end
   end

   always @(negedge clk) begin
      int em, ep;
      em = 0; ep = 0;
      for (int i = 0; i < CH; i++) begin
         em |= (m_match[i] & 1) << i;
         ep |= (m_pwm[i] & 1) << i;
      end
      check("cnt", int'(cnt), m_cnt);
      check("wrap", int'(wrap), m_wrap);
      check("match", int'(match), em);
      check("pwm", int'(pwm_out), ep);
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wr(input int ch, input int d);
      wr_en = 1'b1; wr_ch = WW'(ch); wr_duty = N'(d);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic wait_wrap();
      int k = 0;
      do begin cyc(); k++; end while (!wrap && k < 300);
      if (!wrap) check("wrap_timeout", 0, 1);
   endtask

   task automatic wait_cnt(input int v);
      int k = 0;
      while (int'(cnt) != v && k < 300) begin cyc(); k++; end
      if (int'(cnt) != v) check("cnt_timeout", int'(cnt), v);
   endtask

   initial begin
      int hi[CH];
      int nm, nw;
      rst = 1'b1; en = 1'b0; mode = 1'b0; period = '0;
      wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
      repeat (2) cyc();
      check("rst_cnt", int'(cnt), 0);
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_wrap", int'(wrap), 0);
      rst = 1'b0;

      // level mode, duties 0/3/9/12 at period 9
      period = N'(9); en = 1'b1;
      wr(0, 0); wr(1, 3); wr(2, 9); wr(3, 12);
      wait_wrap();
      for (int i = 0; i < CH; i++) hi[i] = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      end
      check("lvl_ch0", hi[0], 0);
      check("lvl_ch1", hi[1], 3);
      check("lvl_ch2", hi[2], 9);
      check("lvl_ch3", hi[3], 10);

      // duty write mid-period waits for the next wrap
      wr(1, 2);
      wait_wrap();
      hi[1] = 0;
      for (int k = 0; k < 10; k++) begin
         if (int'(cnt) == 4) begin
            wr_en = 1'b1; wr_ch = WW'(1); wr_duty = N'(5);
         end else wr_en = 1'b0;
         cyc();
         hi[1] += int'(pwm_out[1]);
      end
      wr_en = 1'b0;
      check("shadow_cur", hi[1], 2);
      hi[1] = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         hi[1] += int'(pwm_out[1]);
      end
      check("shadow_next", hi[1], 5);

      // toggle mode, period 7, duty 3
      mode = 1'b1; period = N'(7);
      wr(0, 3);
      wait_wrap();
      wait_wrap();
      nm = 0; hi[0] = 0;
      for (int k = 0; k < 16; k++) begin
         cyc();
         nm += int'(match[0]);
         hi[0] += int'(pwm_out[0]);
      end
      check("tog_match", nm, 2);
      check("tog_high", hi[0], 8);

      // lower period below running count
      mode = 1'b0; period = N'(20);
      wait_wrap();
      wait_cnt(12);
      period = N'(5);
      cyc();
      check("lower_cnt", int'(cnt), 0);
      check("lower_wrap", int'(wrap), 0);
      nw = 0;
      for (int k = 0; k < 12; k++) begin
         cyc();
         nw += int'(wrap);
      end
      check("lower_wraps", nw, 2);

      // period 0 then freeze
      period = '0;
      repeat (2) cyc();
      check("p0_cnt", int'(cnt), 0);
      check("p0_wrap", int'(wrap), 1);
      period = N'(9);
      repeat (3) cyc();
      check("run_cnt", int'(cnt), 3);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("frz_cnt", int'(cnt), 3);
         check("frz_wrap", int'(wrap), 0);
         check("frz_match", int'(match), 0);
      end
      en = 1'b1;

      // asynchronous reset mid-period
      wait_cnt(6);
      #2 rst = 1'b1;
      #1;
      check("arst_cnt", int'(cnt), 0);
      check("arst_pwm", int'(pwm_out), 0);
      check("arst_match", int'(match), 0);
      cyc();
      rst = 1'b0;
      cyc();
      check("rel_cnt1", int'(cnt), 1);
      cyc();
      check("rel_cnt2", int'(cnt), 2);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 39) == 0) mode = ~mode;
         if ($urandom_range(0, 29) == 0)
            period = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 127))
                                                 : N'($urandom_range(0, 15));
         wr_en = ($urandom_range(0, 1) == 1);
         wr_ch = WW'($urandom_range(0, CH - 1));
         wr_duty = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 127))
                                               : N'($urandom_range(0, 17));
         cyc();
      end
      wr_en = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pwm_cmp_bank.md
PWM_CMP_BANK -- requirements
Module: pwm_cmp_bank

Interface
REQ-001 Parameter N, default 7, sets counter, period and duty width in bits.
REQ-002 Parameter CH, default 4, sets the number of compare channels (1..16).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  count enable; 0 freezes the counter and all outputs.
REQ-006 mode  input  1  output mode: 0 = level PWM, 1 = toggle-on-match.
REQ-007 period  input  N  terminal count; the counter runs 0..period inclusive.
REQ-008 wr_en  input  1  duty write strobe, one write per cycle.
REQ-009 wr_ch  input  max(1,clog2(CH))  channel index for the duty write.
REQ-010 wr_duty  input  N  duty value written into the shadow register of channel wr_ch.
REQ-011 cnt  output  N  current counter value.
REQ-012 wrap  output  1  one-cycle pulse, registered, asserted on the cycle after counter value period is counted.
REQ-013 match  output  CH  per-channel one-cycle pulse, registered, asserted when cnt equals the active duty.
REQ-014 pwm_out  output  CH  per-channel PWM output, registered.

Function
REQ-015 With en=1, the counter increments by 1 each cycle and reloads 0 on the cycle after cnt==period.
REQ-016 If cnt>period (period lowered mid-run), the counter shall reload 0 on the next enabled cycle.
REQ-017 Each channel shall hold a shadow duty and an active duty, both N bits wide.
REQ-018 wr_en=1 shall load wr_duty into the shadow duty of channel wr_ch; an out-of-range wr_ch is ignored.
REQ-019 Active duty shall load from shadow only on an enabled cycle where cnt==period, so active duty is glitch-free within a period.
REQ-020 If a write coincides with the load cycle, the new wr_duty value shall reach both shadow and active duty.
REQ-021 match[i] and wrap shall be asserted exactly one cycle after the cnt value that caused them (latency 1).
REQ-022 In mode 0, pwm_out[i] shall equal the registered value of (cnt < active_duty[i]).
REQ-023 Mode 0 boundary cases: duty=0 gives a constant 0 output; duty>period gives a constant 1 output.
REQ-024 In mode 1, pwm_out[i] shall toggle on each match[i] pulse.
REQ-025 In mode 1, pwm_out[i] holds its value when duty>period, because no match occurs.
REQ-026 A mode change shall take effect at the next wrap; until then the previous mode stays active.
REQ-027 period=0 shall produce cnt=0 constantly and wrap asserted every enabled cycle.
REQ-028 With en=0, no counter, match, wrap, active-duty or pwm_out update shall occur.
REQ-029 While en=0, match and wrap shall read 0 and shadow writes are still accepted.
REQ-030 Compare arithmetic shall be unsigned N-bit with no carry-out; the counter never exceeds 2^N-1.

Reset
REQ-031 rst=1 shall asynchronously clear cnt, all shadow and active duties, match, wrap and pwm_out to 0.
REQ-032 rst=1 shall asynchronously clear the latched mode to 0.
REQ-033 Reset asserted mid-period shall abort the period; after release, counting restarts at 0 on the first enabled edge.

Structure
REQ-034 Shared package pwm_pkg shall hold the default N and CH values and the MODE_LEVEL=0 / MODE_TOGGLE=1 constants.
REQ-035 The per-channel shadow/active duty, compare and output logic shall live in sub-module pwm_cmp_cell, instantiated CH times.
REQ-036 The counter, wrap logic and write decode shall reside in the top module.

Verification
REQ-037 N=7, CH=4, period=9, mode 0, duties 0/3/9/12 -> per 10-cycle period: ch0 always 0, ch1 high 3 cycles, ch2 high 9 cycles, ch3 always 1.
REQ-038 Write duty 5 to ch1 at cnt=4 of an active-duty-2 period -> high 2 cycles in the current period, 5 cycles from the next wrap onward.
REQ-039 Mode 1, period=7, duty 3 -> match[ch] pulses every 8 cycles; pwm_out toggles with 50% duty and an 8-cycle phase.
REQ-040 Lower period 20->5 while cnt=12 -> cnt=0 next cycle; wrap every 6 cycles thereafter.
REQ-041 period=0 -> wrap held high; en=0 for 5 cycles -> cnt, pwm_out frozen and match/wrap 0.
REQ-042 Assert rst at cnt=6 between clock edges -> all outputs 0 immediately; after release, cnt counts 0,1,2 on subsequent edges.
